interrupt_controller: RTL and testbench

//  Upstream neighbour of the pipeline top. Collects external interrupt sources and feeds the

---
 rtl/interrupt_controller_pkg.sv | 21 ++
 rtl/interrupt_controller_if.sv | 38 +++
 rtl/interrupt_controller_sync_edge.sv | 43 ++++
 rtl/interrupt_controller.sv | 122 ++++++++++++
 tb/tb_interrupt_controller.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_controller_pkg.sv
// ============================================================================
// Module      : interrupt_controller_pkg
// Description : Shared types and constants for the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package interrupt_controller_pkg;

    localparam int unsigned IRQ_NUM_SRC = 4;
    localparam logic [IRQ_NUM_SRC-1:0] IRQ_MASK_ALL = {IRQ_NUM_SRC{1'b1}};

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_t;

endpackage : interrupt_controller_pkg

`default_nettype wire

// File: rtl/interrupt_controller_if.sv
// ============================================================================
// Module      : interrupt_controller_if
// Description : Source, mask-write and processor handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interrupt_controller_if
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SRC = IRQ_NUM_SRC,
    parameter int ID_W    = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0] irq_src;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wdata;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic               cpu_interrupt;
    logic               cpu_ack;
    logic               cpu_eoi;
    logic [ID_W-1:0]    irq_id;
    logic               busy;

    // Controller side
    modport slave (
        input  irq_src, mask_we, mask_wdata, cpu_ack, cpu_eoi,
        output mask, pending, cpu_interrupt, irq_id, busy
    );

    // Processor / system side
    modport master (
        output irq_src, mask_we, mask_wdata, cpu_ack, cpu_eoi,
        input  mask, pending, cpu_interrupt, irq_id, busy
    );
endinterface : interrupt_controller_if

`default_nettype wire

// File: rtl/interrupt_controller_sync_edge.sv
// ============================================================================
// Module      : irq_sync_edge
// Description : Per-source 2-flop synchroniser followed by a rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_sync_edge #(
    parameter int NUM_SRC = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [NUM_SRC-1:0] irq_src,
    output logic      [NUM_SRC-1:0] rise
);
    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;
    logic [NUM_SRC-1:0] sync3_q, sync3_d;

    always_comb begin
        sync1_d = irq_src;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
        end
    end

    // A held level produces a single one-cycle pulse.
    assign rise = sync2_q & ~sync3_q;

endmodule : irq_sync_edge

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module      : interrupt_controller
// Description : Pending/mask registers, fixed-priority select and single
//               in-flight request handshake towards the processor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int                 NUM_SRC  = IRQ_NUM_SRC,
    parameter int                 ID_W     = $clog2(NUM_SRC),
    parameter logic [NUM_SRC-1:0] MASK_RST = {NUM_SRC{1'b1}}
) (
    input wire logic clk,
    input wire logic rst,
    interrupt_controller_if.slave bus
);
    logic [NUM_SRC-1:0] rise;

    irq_sync_edge #(
        .NUM_SRC (NUM_SRC)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .irq_src (bus.irq_src),
        .rise    (rise)
    );

    irq_state_t         state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               cpu_interrupt_q, cpu_interrupt_d;
    logic               busy_q, busy_d;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    sel_id;
    logic               any_eligible;

    // Lowest index wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        eligible     = pending_q & ~mask_q;
        any_eligible = |eligible;
        sel_id       = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        irq_id_d        = irq_id_q;
        cpu_interrupt_d = cpu_interrupt_q;
        busy_d          = busy_q;
        clr             = '0;

        case (state_q)
            IRQ_IDLE: begin
                if (any_eligible) begin
                    irq_id_d        = sel_id;
                    cpu_interrupt_d = 1'b1;
                    busy_d          = 1'b1;
                    state_d         = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                if (bus.cpu_ack) begin
                    clr[irq_id_q]   = 1'b1;
                    cpu_interrupt_d = 1'b0;
                    state_d         = IRQ_SERVICE;
                end
            end
            IRQ_SERVICE: begin
                if (bus.cpu_eoi) begin
                    busy_d  = 1'b0;
                    state_d = IRQ_IDLE;
                end
            end
            default: begin
                state_d         = IRQ_IDLE;
                cpu_interrupt_d = 1'b0;
                busy_d          = 1'b0;
            end
        endcase

        // A new edge arriving with the ack clear keeps the bit set.
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IRQ_IDLE;
            pending_q       <= '0;
            mask_q          <= MASK_RST;
            irq_id_q        <= '0;
            cpu_interrupt_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            mask_q          <= mask_d;
            irq_id_q        <= irq_id_d;
            cpu_interrupt_q <= cpu_interrupt_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.mask          = mask_q;
    assign bus.pending       = pending_q;
    assign bus.irq_id        = irq_id_q;
    assign bus.cpu_interrupt = cpu_interrupt_q;
    assign bus.busy          = busy_q;

endmodule : interrupt_controller

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Directed scenarios plus random traffic against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    interrupt_controller_if #(.NUM_SRC(4), .ID_W(2)) bus ();

    interrupt_controller #(
        .NUM_SRC  (4),
        .ID_W     (2),
        .MASK_RST (4'b1111)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: source samples of the last three edges, pending/mask
    // bit vectors, and a phase: 0 = no request, 1 = awaiting ack, 2 = awaiting eoi.
    logic [3:0] m_pend, m_mask, h0, h1, h2;
    logic       m_int, m_busy;
    logic [1:0] m_id;
    int         m_phase;

    function void model_reset();
        m_pend = 4'b0000; m_mask = 4'b1111;
        h0 = 4'b0000; h1 = 4'b0000; h2 = 4'b0000;
        m_int = 1'b0; m_busy = 1'b0; m_id = 2'd0; m_phase = 0;
    endfunction

    function void model_edge();
        logic [3:0] elig, fresh, clr;
        elig  = m_pend & ~m_mask;
        fresh = h1 & ~h2;
        clr   = 4'b0000;
        if (m_phase == 0 && elig != 4'b0000) begin
            for (int i = 3; i >= 0; i--) if (elig[i]) m_id = 2'(i);
            m_int = 1'b1; m_busy = 1'b1; m_phase = 1;
        end else if (m_phase == 1 && bus.cpu_ack) begin
            clr[m_id] = 1'b1; m_int = 1'b0; m_phase = 2;
        end else if (m_phase == 2 && bus.cpu_eoi) begin
            m_busy = 1'b0; m_phase = 0;
        end
        m_pend = (m_pend & ~clr) | fresh;
        if (bus.mask_we) m_mask = bus.mask_wdata;
        h2 = h1; h1 = h0; h0 = bus.irq_src;
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_edge(); else model_reset();
        #1;
    endtask

    task automatic write_mask(input logic [3:0] v);
        bus.mask_we = 1'b1; bus.mask_wdata = v; step(); bus.mask_we = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.cpu_ack = 1'b1; step(); bus.cpu_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus.cpu_eoi = 1'b1; step(); bus.cpu_eoi = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.cpu_interrupt !== 1'b0) begin errors++; $display("FAIL rst_int: got %b want 0", bus.cpu_interrupt); end
        checks++; if (bus.mask !== 4'b1111) begin errors++; $display("FAIL rst_mask: got %b want 1111", bus.mask); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        rst = 1'b1;
        write_mask(4'b0000);
        bus.irq_src = 4'b1000;
        for (int i = 0; i < 10 && bus.cpu_interrupt !== 1'b1; i++) step();
        checks++; if (bus.cpu_interrupt !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", bus.cpu_interrupt); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.cpu_interrupt !== 1'b0) begin errors++; $display("FAIL rst_mid_int: got %b want 0", bus.cpu_interrupt); end
        checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL rst_mid_pend: got %b want 0000", bus.pending); end
        checks++; if (bus.mask !== 4'b1111) begin errors++; $display("FAIL rst_mid_mask: got %b want 1111", bus.mask); end
        checks++; if (bus.irq_id !== 2'd0) begin errors++; $display("FAIL rst_mid_id: got %0d want 0", bus.irq_id); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        model_reset();
        bus.irq_src = 4'b0000;
        step();
        rst = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_single();
        write_mask(4'b0000);
        bus.irq_src = 4'b0100;
        step();
        step();
        checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL single_early: got %b want 0000", bus.pending); end
        step();
        checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL single_pend: got %b want 0100", bus.pending); end
        step();
        checks++; if (bus.cpu_interrupt !== 1'b1 || bus.irq_id !== 2'd2) begin errors++; $display("FAIL single_req: got int=%b id=%0d want int=1 id=2", bus.cpu_interrupt, bus.irq_id); end
        pulse_ack();
        checks++; if (bus.pending !== 4'b0000 || bus.cpu_interrupt !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_ack: got pend=%b int=%b busy=%b want 0000 0 1", bus.pending, bus.cpu_interrupt, bus.busy); end
        pulse_eoi();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_eoi: got busy=%b want 0", bus.busy); end
        bus.irq_src = 4'b0000;
        repeat (4) step();
    endtask

    task automatic test_priority();
        bus.irq_src = 4'b1010;
        repeat (4) step();
        checks++; if (bus.cpu_interrupt !== 1'b1 || bus.irq_id !== 2'd1) begin errors++; $display("FAIL prio_first: got int=%b id=%0d want int=1 id=1", bus.cpu_interrupt, bus.irq_id); end
        pulse_ack();
        pulse_eoi();
        step();
        checks++; if (bus.cpu_interrupt !== 1'b1 || bus.irq_id !== 2'd3) begin errors++; $display("FAIL prio_second: got int=%b id=%0d want int=1 id=3", bus.cpu_interrupt, bus.irq_id); end
        checks++; if (bus.pending !== 4'b1000) begin errors++; $display("FAIL prio_pend: got %b want 1000", bus.pending); end
        pulse_ack();
        pulse_eoi();
        bus.irq_src = 4'b0000;
        repeat (4) step();
    endtask

    task automatic test_masking();
        int seen;
        write_mask(4'b0001);
        bus.irq_src = 4'b0001;
        step();
        bus.irq_src = 4'b0000;
        repeat (2) step();
        checks++; if (bus.pending !== 4'b0001) begin errors++; $display("FAIL mask_pend: got %b want 0001", bus.pending); end
        seen = 0;
        repeat (10) begin
            step();
            if (bus.cpu_interrupt !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mask_hold: got %0d request cycles want 0", seen); end
        write_mask(4'b0000);
        step();
        checks++; if (bus.cpu_interrupt !== 1'b1 || bus.irq_id !== 2'd0) begin errors++; $display("FAIL mask_unmask: got int=%b id=%0d want int=1 id=0", bus.cpu_interrupt, bus.irq_id); end
        pulse_ack();
        pulse_eoi();
        step();
    endtask

    task automatic test_collision();
        bus.irq_src = 4'b0010;
        repeat (4) step();
        checks++; if (bus.cpu_interrupt !== 1'b1 || bus.irq_id !== 2'd1) begin errors++; $display("FAIL coll_req: got int=%b id=%0d want int=1 id=1", bus.cpu_interrupt, bus.irq_id); end
        bus.irq_src = 4'b0000;
        step();
        bus.irq_src = 4'b0010;
        step();
        step();
        pulse_ack();
        checks++; if (bus.pending[1] !== 1'b1 || bus.cpu_interrupt !== 1'b0) begin errors++; $display("FAIL coll_set_wins: got pend=%b int=%b want pend[1]=1 int=0", bus.pending, bus.cpu_interrupt); end
        pulse_eoi();
        step();
        checks++; if (bus.cpu_interrupt !== 1'b1 || bus.irq_id !== 2'd1) begin errors++; $display("FAIL coll_rereq: got int=%b id=%0d want int=1 id=1", bus.cpu_interrupt, bus.irq_id); end
        pulse_ack();
        pulse_eoi();
        bus.irq_src = 4'b0000;
        repeat (4) step();
    endtask

    task automatic test_ignored();
        int extra;
        pulse_eoi();
        checks++; if (bus.busy !== 1'b0 || bus.cpu_interrupt !== 1'b0) begin errors++; $display("FAIL ign_eoi_idle: got busy=%b int=%b want 0 0", bus.busy, bus.cpu_interrupt); end
        bus.irq_src = 4'b0001;
        repeat (4) step();
        checks++; if (bus.cpu_interrupt !== 1'b1 || bus.irq_id !== 2'd0) begin errors++; $display("FAIL level_req: got int=%b id=%0d want int=1 id=0", bus.cpu_interrupt, bus.irq_id); end
        pulse_ack();
        pulse_ack();
        checks++; if (bus.busy !== 1'b1 || bus.cpu_interrupt !== 1'b0) begin errors++; $display("FAIL ign_ack_svc: got busy=%b int=%b want 1 0", bus.busy, bus.cpu_interrupt); end
        pulse_eoi();
        extra = 0;
        repeat (13) begin
            step();
            if (bus.cpu_interrupt !== 1'b0) extra++;
        end
        checks++; if (extra != 0 || bus.pending !== 4'b0000) begin errors++; $display("FAIL level_once: got %0d extra cycles pend=%b want 0 0000", extra, bus.pending); end
        bus.irq_src = 4'b0000;
        repeat (4) step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) bus.irq_src[b] = ~bus.irq_src[b];
            bus.mask_we    = ($urandom_range(0, 15) == 0);
            bus.mask_wdata = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            bus.cpu_ack    = ($urandom_range(0, 2) == 0);
            bus.cpu_eoi    = ($urandom_range(0, 3) == 0);
            step();
            checks++; if (bus.pending !== m_pend) begin errors++; $display("FAIL rnd_pend @%0d: got %b want %b", n, bus.pending, m_pend); end
            checks++; if (bus.mask !== m_mask) begin errors++; $display("FAIL rnd_mask @%0d: got %b want %b", n, bus.mask, m_mask); end
            checks++; if (bus.cpu_interrupt !== m_int) begin errors++; $display("FAIL rnd_int @%0d: got %b want %b", n, bus.cpu_interrupt, m_int); end
            checks++; if (bus.busy !== m_busy) begin errors++; $display("FAIL rnd_busy @%0d: got %b want %b", n, bus.busy, m_busy); end
            checks++; if (bus.irq_id !== m_id) begin errors++; $display("FAIL rnd_id @%0d: got %0d want %0d", n, bus.irq_id, m_id); end
        end
        bus.mask_we = 1'b0; bus.cpu_ack = 1'b0; bus.cpu_eoi = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        bus.irq_src    = 4'b0000;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = 4'b0000;
        bus.cpu_ack    = 1'b0;
        bus.cpu_eoi    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_priority();
        test_masking();
        test_collision();
        test_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_interrupt_controller

`default_nettype wire
